wishbone_line_responder: RTL and testbench

//  Wishbone slave endpoint backed by an internal line-wide RAM. It answers each
//  CYC&STB request with a one-cycle ACK after a programmable latency, or with RTY.

---
 rtl/wishbone_line_responder_pkg.sv | 15 +
 rtl/wishbone_line_responder_if.sv | 29 ++
 rtl/wishbone_line_responder_ram.sv | 39 +++
 rtl/wishbone_line_responder.sv | 136 +++++++++++++
 tb/tb_wishbone_line_responder.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wishbone_line_responder_pkg.sv
// Shared widths and the response FSM state type for the wishbone line responder.
package wishbone_line_responder_pkg;

  localparam int WB_DATA_WIDTH = 256;
  localparam int WB_ADR_WIDTH  = 27;
  localparam int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8;
  localparam int WB_CNT_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_resp_state_t;

endpackage

// File: rtl/wishbone_line_responder_if.sv
// Classic wishbone request/response bundle; master drives the request, slave answers.
interface wishbone_line_responder_if
  import wishbone_line_responder_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ADR_WIDTH  = WB_ADR_WIDTH
);

  logic                      CYC;
  logic                      STB;
  logic                      WE;
  logic [DATA_WIDTH/8-1:0]   SEL;
  logic [ADR_WIDTH-1:0]      ADR;
  logic [DATA_WIDTH-1:0]     DAT_M;
  logic [DATA_WIDTH-1:0]     DAT_S;
  logic                      ACK;
  logic                      RTY;

  modport master (
    output CYC, STB, WE, SEL, ADR, DAT_M,
    input  DAT_S, ACK, RTY
  );

  modport slave (
    input  CYC, STB, WE, SEL, ADR, DAT_M,
    output DAT_S, ACK, RTY
  );

endinterface

// File: rtl/wishbone_line_responder_ram.sv
// Single-port line RAM: byte-masked synchronous write, registered read that holds
// its value until the next read. Only the read register is reset.
module wb_line_ram #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 512,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we_i,
  input  logic                    re_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [AW-1:0]           addr_i,
  input  logic [DATA_WIDTH-1:0]   wdat_i,
  output logic [DATA_WIDTH-1:0]   rdat_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdat_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < DATA_WIDTH / 8; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdat_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdat_q <= '0;
    end else if (re_i) begin
      rdat_q <= mem_q[addr_i];
    end
  end

  assign rdat_o = rdat_q;

endmodule

// File: rtl/wishbone_line_responder.sv
// Wishbone slave over a line RAM: latches each CYC&STB request, waits LATENCY cycles
// (abortable by a CYC/STB drop), then pulses ACK (in range) or RTY (out of range).
module wishbone_line_responder
  import wishbone_line_responder_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ADR_WIDTH  = WB_ADR_WIDTH,
  parameter int DEPTH      = 512,
  parameter int LATENCY    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  wishbone_line_responder_if.slave    wb
);

  localparam int SEL_W  = DATA_WIDTH / 8;
  localparam int RAM_AW = $clog2(DEPTH);
  localparam int CNT_W  = WB_CNT_WIDTH;

  wb_resp_state_t          state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    we_q, we_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [ADR_WIDTH-1:0]    adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic                    ack_q, ack_d;
  logic                    rty_q, rty_d;

  logic                    req;
  logic                    enter_resp;
  logic                    cur_we;
  logic [SEL_W-1:0]        cur_sel;
  logic [ADR_WIDTH-1:0]    cur_adr;
  logic [DATA_WIDTH-1:0]   cur_dat;
  logic                    in_range;
  logic                    ram_we;
  logic                    ram_re;

  assign req = wb.CYC & wb.STB;

  // With LATENCY==1 the response is decided on the sample edge itself, before the
  // latch holds anything, so the live bus feeds the RAM while still in IDLE.
  assign cur_we   = (state_q == IDLE) ? wb.WE    : we_q;
  assign cur_sel  = (state_q == IDLE) ? wb.SEL   : sel_q;
  assign cur_adr  = (state_q == IDLE) ? wb.ADR   : adr_q;
  assign cur_dat  = (state_q == IDLE) ? wb.DAT_M : dat_q;
  assign in_range = (cur_adr < ADR_WIDTH'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      rty_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      rty_q   <= rty_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = wb.WE;
          sel_d   = wb.SEL;
          adr_d   = wb.ADR;
          dat_d   = wb.DAT_M;
          count_d = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        // Leaving WAIT when the count reaches zero on this edge.
        count_d = count_q - 1'b1;
        if (!req) begin
          state_d = IDLE;
          count_d = '0;
        end else if (count_q == CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        count_d = '0;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_comb begin
    enter_resp = (state_q != RESP) && (state_d == RESP);
    ram_we     = enter_resp && cur_we && in_range;
    ram_re     = enter_resp && !cur_we && in_range;
    ack_d      = enter_resp && in_range;
    rty_d      = enter_resp && !in_range;
  end

  wb_line_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (RAM_AW)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .be_i   (cur_sel),
    .addr_i (cur_adr[RAM_AW-1:0]),
    .wdat_i (cur_dat),
    .rdat_o (wb.DAT_S)
  );

  assign wb.ACK = ack_q;
  assign wb.RTY = rty_q;

endmodule

// File: tb/tb_wishbone_line_responder.sv
// Directed scoreboard bench driving three responders (LATENCY 1, 4, 15) one at a time.
module tb_wishbone_line_responder;
  import wishbone_line_responder_pkg::*;

  localparam int DW    = 256;
  localparam int AW    = 27;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 512;

  typedef struct {
    logic          ack;
    logic          rty;
    logic [DW-1:0] dat;
  } exp_t;

  logic          clk = 1'b0;
  logic [2:0]    rst_n_b;
  logic          cyc_b, stb_b, we_b;
  logic [SW-1:0] sel_b;
  logic [AW-1:0] adr_b;
  logic [DW-1:0] datm_b;
  int            cur;
  int            lat;
  logic          ack_m, rty_m;
  logic [DW-1:0] dat_m;

  int            checks = 0;
  int            failures = 0;
  exp_t          sb[$];
  logic [DW-1:0] mdl [int];
  logic [DW-1:0] last_dat [3];

  always #5 clk = ~clk;

  wishbone_line_responder_if #(.DATA_WIDTH(DW), .ADR_WIDTH(AW)) wb0 ();
  wishbone_line_responder_if #(.DATA_WIDTH(DW), .ADR_WIDTH(AW)) wb1 ();
  wishbone_line_responder_if #(.DATA_WIDTH(DW), .ADR_WIDTH(AW)) wb2 ();

  assign wb0.CYC = cyc_b && (cur == 0);
  assign wb0.STB = stb_b && (cur == 0);
  assign wb0.WE = we_b;
  assign wb0.SEL = sel_b;
  assign wb0.ADR = adr_b;
  assign wb0.DAT_M = datm_b;
  assign wb1.CYC = cyc_b && (cur == 1);
  assign wb1.STB = stb_b && (cur == 1);
  assign wb1.WE = we_b;
  assign wb1.SEL = sel_b;
  assign wb1.ADR = adr_b;
  assign wb1.DAT_M = datm_b;
  assign wb2.CYC = cyc_b && (cur == 2);
  assign wb2.STB = stb_b && (cur == 2);
  assign wb2.WE = we_b;
  assign wb2.SEL = sel_b;
  assign wb2.ADR = adr_b;
  assign wb2.DAT_M = datm_b;

  wishbone_line_responder #(.DATA_WIDTH(DW), .ADR_WIDTH(AW), .DEPTH(DEPTH), .LATENCY(1))
    dut0 (.clk(clk), .rst_n(rst_n_b[0]), .wb(wb0));
  wishbone_line_responder #(.DATA_WIDTH(DW), .ADR_WIDTH(AW), .DEPTH(DEPTH), .LATENCY(4))
    dut1 (.clk(clk), .rst_n(rst_n_b[1]), .wb(wb1));
  wishbone_line_responder #(.DATA_WIDTH(DW), .ADR_WIDTH(AW), .DEPTH(DEPTH), .LATENCY(15))
    dut2 (.clk(clk), .rst_n(rst_n_b[2]), .wb(wb2));

  always_comb begin
    ack_m = wb0.ACK;
    rty_m = wb0.RTY;
    dat_m = wb0.DAT_S;
    if (cur == 1) begin
      ack_m = wb1.ACK;
      rty_m = wb1.RTY;
      dat_m = wb1.DAT_S;
    end else if (cur == 2) begin
      ack_m = wb2.ACK;
      rty_m = wb2.RTY;
      dat_m = wb2.DAT_S;
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s (dut lat=%0d): observed=%0h expected=%0h", tag, lat, obs, exp);
    end
  endtask

  // Reference model: updates the per-DUT line image and queues the expected response.
  task automatic push_exp(input logic w, input logic [SW-1:0] s, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    exp_t          e;
    int            key;
    logic [DW-1:0] line;
    e.ack = 1'b0;
    e.rty = 1'b0;
    e.dat = last_dat[cur];
    if (a < AW'(DEPTH)) begin
      key   = cur * 1024 + int'(a);
      line  = mdl.exists(key) ? mdl[key] : {DW{1'bx}};
      e.ack = 1'b1;
      if (w) begin
        for (int i = 0; i < SW; i++) if (s[i]) line[8*i +: 8] = d[8*i +: 8];
        mdl[key] = line;
      end else begin
        e.dat = line;
        last_dat[cur] = line;
      end
    end else begin
      e.rty = 1'b1;
    end
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, DW'(1), DW'(0));
    end else begin
      e = sb.pop_front();
      check({tag, "_ack"}, DW'(ack_m), DW'(e.ack));
      check({tag, "_rty"}, DW'(rty_m), DW'(e.rty));
      check({tag, "_dat"}, dat_m, e.dat);
    end
  endtask

  task automatic drive(input logic w, input logic [SW-1:0] s, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    cyc_b = 1'b1; stb_b = 1'b1; we_b = w; sel_b = s; adr_b = a; datm_b = d;
  endtask

  task automatic transact(input string tag, input logic w, input logic [SW-1:0] s,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    int k;
    push_exp(w, s, a, d);
    @(negedge clk);
    drive(w, s, a, d);
    @(posedge clk);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(ack_m || rty_m) && k < lat + 3);
    check({tag, "_latency"}, DW'(k), DW'(lat));
    if (ack_m || rty_m) begin
      pop_check(tag);
      check({tag, "_ack_rty_both"}, DW'(ack_m & rty_m), DW'(0));
    end else begin
      void'(sb.pop_front());
    end
    cyc_b = 1'b0; stb_b = 1'b0;
    @(negedge clk);
    check({tag, "_pulse_width"}, DW'(ack_m | rty_m), DW'(0));
  endtask

  initial begin
    int            k, acks, resp;
    logic [DW-1:0] patt_a5, patt_9, all_ones;
    patt_a5  = {32{8'hA5}};
    patt_9   = {8{32'h1234_5678}};
    all_ones = '1;
    rst_n_b = 3'b000;
    cyc_b = 1'b0; stb_b = 1'b0; we_b = 1'b0; sel_b = '0; adr_b = '0; datm_b = '0;
    cur = 0; lat = 1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      cur = d;
      lat = (d == 0) ? 1 : (d == 1) ? 4 : 15;
      last_dat[d] = '0;
      #1;
      check("reset_ack", DW'(ack_m), DW'(0));
      check("reset_rty", DW'(rty_m), DW'(0));
      check("reset_dat", dat_m, DW'(0));
    end
    @(negedge clk);
    rst_n_b = 3'b111;

    for (int d = 0; d < 3; d++) begin
      cur = d;
      lat = (d == 0) ? 1 : (d == 1) ? 4 : 15;

      transact("wr5", 1'b1, '1, AW'(5), patt_a5);
      transact("rd5", 1'b0, '1, AW'(5), '0);
      transact("rd_oor", 1'b0, '1, AW'(DEPTH), '0);
      transact("rd5_after_oor", 1'b0, '1, AW'(5), '0);

      transact("wr7_zero", 1'b1, '1, AW'(7), '0);
      transact("wr7_partial", 1'b1, SW'(32'h0000_000F), AW'(7), all_ones);
      transact("rd7", 1'b0, '1, AW'(7), '0);

      transact("wr9", 1'b1, '1, AW'(9), patt_9);
      if (lat > 2) begin
        // Abort: STB drops so the edge two cycles after the sample sees it low.
        @(negedge clk);
        drive(1'b1, '1, AW'(9), ~patt_9);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        cyc_b = 1'b0; stb_b = 1'b0;
        resp = 0;
        repeat (lat + 3) begin
          @(negedge clk);
          if (ack_m || rty_m) resp++;
        end
        check("abort_no_resp", DW'(resp), DW'(0));
      end
      transact("rd9", 1'b0, '1, AW'(9), '0);

      // Back-to-back: STB held across three reads of line 5.
      for (int i = 0; i < 3; i++) push_exp(1'b0, '1, AW'(5), '0);
      @(negedge clk);
      drive(1'b0, '1, AW'(5), '0);
      @(posedge clk);
      acks = 0;
      k = 0;
      while (k < 3 * (lat + 1) + 4) begin
        @(negedge clk);
        k++;
        if (ack_m || rty_m) begin
          check("b2b_pos", DW'(k), DW'(acks * (lat + 1) + lat));
          pop_check("b2b");
          acks++;
          if (acks == 3) begin
            cyc_b = 1'b0; stb_b = 1'b0;
          end
        end
      end
      check("b2b_count", DW'(acks), DW'(3));
      cyc_b = 1'b0; stb_b = 1'b0;
      while (sb.size() > 0) void'(sb.pop_front());

      if (lat > 1) begin
        @(negedge clk);
        drive(1'b1, '1, AW'(9), ~patt_9);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n_b[cur] = 1'b0;
        #1;
        check("rst_ack", DW'(ack_m), DW'(0));
        check("rst_rty", DW'(rty_m), DW'(0));
        check("rst_dat", dat_m, DW'(0));
        last_dat[cur] = '0;
        cyc_b = 1'b0; stb_b = 1'b0;
        @(negedge clk);
        rst_n_b[cur] = 1'b1;
        transact("rd9_after_rst", 1'b0, '1, AW'(9), '0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
